mips_cpu_mem_port: RTL and testbench

Memory port of the multicycle MIPS core: it sits directly downstream of the CPU control state machine and turns its instruction-fetch and load/store requests into Avalon-MM master transactions on the single unified memory bus. It returns fetched words and load data to the datapath. It also drives the `wait_request` stall that freezes the state machine until the bus access completes.

---
 rtl/mips_cpu_mem_port.sv | 188 ++++++++++++++++++
 tb/tb_mips_cpu_mem_port.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mem_port.sv
// mips_cpu_mem_port: memory port of the multicycle MIPS core.
// Turns instruction-fetch and load/store requests from the CPU control FSM
// into Avalon-MM master transactions on the unified memory bus. It returns
// read words on rdata and stalls the control FSM through wait_request.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   fetch_req, pc            instruction fetch request / byte address
//   data_rd_req, data_wr_req load / store requests
//   data_addr, data_wdata    load/store byte address, store data
//   data_be                  load/store byte enables
//   wait_request             combinational stall to the control FSM
//   done                     one-cycle completion pulse
//   rdata                    last read word (fetch or load)
//   misaligned               one-cycle pulse, request rejected (addr[1:0]!=0)
//   timeout                  sticky watchdog flag
//   avm_*                    Avalon-MM master interface (outputs registered)
//
// Optional feature: define MEM_PORT_TIMEOUT_EN to enable the waitrequest
// watchdog (TIMEOUT_CYCLES wait cycles per access). Without it, ACCESS
// waits indefinitely and timeout stays 0.
module mips_cpu_mem_port #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_req,
   input  logic [31:0] pc,
   input  logic        data_rd_req,
   input  logic        data_wr_req,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_be,
   output logic        wait_request,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        timeout,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   // Elaboration-time sanity check on the watchdog limit
   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] avm_address_nxt, avm_writedata_nxt, rdata_nxt;
   logic [3:0]  avm_byteenable_nxt;
   logic        avm_read_nxt, avm_write_nxt;
   logic        done_nxt, misaligned_nxt, timeout_nxt;

`ifdef MEM_PORT_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
`endif

   // Arbitration: store > load > fetch
   logic        any_req;
   logic        data_sel;
   logic [31:0] sel_addr;
   logic        sel_aligned;

   assign any_req     = fetch_req | data_rd_req | data_wr_req;
   assign data_sel    = data_wr_req | data_rd_req;
   assign sel_addr    = data_sel ? data_addr : pc;
   assign sel_aligned = (sel_addr[1:0] == 2'b00);

   // Stall: busy on the bus, or an aligned request about to be issued.
   // The done cycle is left unstalled so the control FSM advances once.
   assign wait_request = (state != IDLE) || (any_req && !done && sel_aligned);

   // Next-state and next-output logic
   always_comb begin
      state_nxt          = state;
      avm_address_nxt    = avm_address;
      avm_read_nxt       = avm_read;
      avm_write_nxt      = avm_write;
      avm_writedata_nxt  = avm_writedata;
      avm_byteenable_nxt = avm_byteenable;
      rdata_nxt          = rdata;
      done_nxt           = 1'b0;
      misaligned_nxt     = 1'b0;
      timeout_nxt        = timeout;
`ifdef MEM_PORT_TIMEOUT_EN
      wait_cnt_nxt       = '0;
`endif

      unique case (state)
         IDLE: begin
            // A request still high in the done/misaligned cycle is the one
            // just finished, so it is not re-issued.
            if (any_req && !done && !misaligned) begin
               if (!sel_aligned) begin
                  misaligned_nxt = 1'b1;
               end else begin
                  avm_address_nxt    = sel_addr;
                  avm_writedata_nxt  = data_wdata;
                  avm_byteenable_nxt = data_sel ? data_be : 4'hF;
                  avm_write_nxt      = data_wr_req;
                  avm_read_nxt       = !data_wr_req;
                  state_nxt          = ACCESS;
               end
            end
         end

         ACCESS: begin
            if (!avm_waitrequest) begin
               avm_read_nxt  = 1'b0;
               avm_write_nxt = 1'b0;
               if (avm_write) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = CAPTURE;
               end
            end
`ifdef MEM_PORT_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Watchdog abort: this edge is the last permitted wait cycle
               avm_read_nxt  = 1'b0;
               avm_write_nxt = 1'b0;
               timeout_nxt   = 1'b1;
               done_nxt      = 1'b1;
               if (avm_read) rdata_nxt = 32'hDEAD_BEEF;
               state_nxt     = IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
`endif
         end

         CAPTURE: begin
            rdata_nxt = avm_readdata;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         avm_address    <= '0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
         avm_byteenable <= '0;
         rdata          <= '0;
         done           <= 1'b0;
         misaligned     <= 1'b0;
         timeout        <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
         wait_cnt       <= '0;
`endif
      end else begin
         state          <= state_nxt;
         avm_address    <= avm_address_nxt;
         avm_read       <= avm_read_nxt;
         avm_write      <= avm_write_nxt;
         avm_writedata  <= avm_writedata_nxt;
         avm_byteenable <= avm_byteenable_nxt;
         rdata          <= rdata_nxt;
         done           <= done_nxt;
         misaligned     <= misaligned_nxt;
         timeout        <= timeout_nxt;
`ifdef MEM_PORT_TIMEOUT_EN
         wait_cnt       <= wait_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_mips_cpu_mem_port.sv
// tb_mips_cpu_mem_port: directed self-checking bench for mips_cpu_mem_port.
// Inputs are driven and outputs sampled on the falling clock edge; the
// bench plays the Avalon slave by driving avm_waitrequest/avm_readdata.
module tb_mips_cpu_mem_port;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_req, data_rd_req, data_wr_req;
   logic [31:0] pc, data_addr, data_wdata;
   logic [3:0]  data_be;
   logic        wait_request, done, misaligned, timeout;
   logic [31:0] rdata;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic        avm_read, avm_write, avm_waitrequest;
   logic [3:0]  avm_byteenable;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mips_cpu_mem_port #(.TIMEOUT_CYCLES(8)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .fetch_req       (fetch_req),
      .pc              (pc),
      .data_rd_req     (data_rd_req),
      .data_wr_req     (data_wr_req),
      .data_addr       (data_addr),
      .data_wdata      (data_wdata),
      .data_be         (data_be),
      .wait_request    (wait_request),
      .done            (done),
      .rdata           (rdata),
      .misaligned      (misaligned),
      .timeout         (timeout),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge (one rising edge in between)
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      fetch_req = 1'b0; data_rd_req = 1'b0; data_wr_req = 1'b0;
      pc = '0; data_addr = '0; data_wdata = '0; data_be = '0;
      avm_waitrequest = 1'b0; avm_readdata = '0;
      step(); step(); step();

      // Reset values
      chk("rst_read",    32'(avm_read), 32'd0);
      chk("rst_write",   32'(avm_write), 32'd0);
      chk("rst_addr",    avm_address, 32'd0);
      chk("rst_be",      32'(avm_byteenable), 32'd0);
      chk("rst_wdata",   avm_writedata, 32'd0);
      chk("rst_rdata",   rdata, 32'd0);
      chk("rst_done",    32'(done), 32'd0);
      chk("rst_misal",   32'(misaligned), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_wait",    32'(wait_request), 32'd0);
      reset_n = 1'b1;
      step();

      // Fetch, zero-wait slave
      fetch_req = 1'b1; pc = 32'hBFC0_0000;
      avm_waitrequest = 1'b0; avm_readdata = 32'h2402_0005;
      #1 chk("f_wait_pre", 32'(wait_request), 32'd1);
      step();                                          // after E0
      chk("f_read_e0", 32'(avm_read), 32'd1);
      chk("f_addr",    avm_address, 32'hBFC0_0000);
      chk("f_be",      32'(avm_byteenable), 32'hF);
      chk("f_wait_e0", 32'(wait_request), 32'd1);
      step();                                          // after E1: CAPTURE
      chk("f_read_e1", 32'(avm_read), 32'd0);
      chk("f_done_e1", 32'(done), 32'd0);
      chk("f_wait_e1", 32'(wait_request), 32'd1);
      step();                                          // after E2: done
      chk("f_done_e2", 32'(done), 32'd1);
      chk("f_rdata",   rdata, 32'h2402_0005);
      chk("f_wait_e2", 32'(wait_request), 32'd0);
      step();                                          // request still high at E3
      chk("f_noreissue", 32'(avm_read), 32'd0);
      chk("f_done_e3",   32'(done), 32'd0);
      fetch_req = 1'b0;
      step();

      // Store with four waitrequest cycles
      data_wr_req = 1'b1; data_addr = 32'h0000_1004;
      data_wdata = 32'hCAFE_F00D; data_be = 4'b0011;
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();                                       // after E0..E4
         chk("s_write", 32'(avm_write), 32'd1);
         chk("s_addr",  avm_address, 32'h0000_1004);
         chk("s_data",  avm_writedata, 32'hCAFE_F00D);
         chk("s_be",    32'(avm_byteenable), 32'h3);
         chk("s_done",  32'(done), 32'd0);
         if (i == 4) avm_waitrequest = 1'b0;
      end
      step();                                          // after E5
      chk("s_done_e5",  32'(done), 32'd1);
      chk("s_write_e5", 32'(avm_write), 32'd0);
      chk("s_wait_e5",  32'(wait_request), 32'd0);
      chk("s_rdata_kept", rdata, 32'h2402_0005);
      data_wr_req = 1'b0;
      step();
      chk("s_done_e6", 32'(done), 32'd0);

      // Fetch and load together: load wins, fetch is dropped
      fetch_req = 1'b1; pc = 32'h0000_0100;
      data_rd_req = 1'b1; data_addr = 32'h0000_2000; data_be = 4'b0101;
      avm_readdata = 32'h1122_3344;
      step();
      chk("a_read", 32'(avm_read), 32'd1);
      chk("a_addr", avm_address, 32'h0000_2000);
      chk("a_be",   32'(avm_byteenable), 32'h5);
      step();
      step();
      chk("a_done",  32'(done), 32'd1);
      chk("a_rdata", rdata, 32'h1122_3344);
      fetch_req = 1'b0; data_rd_req = 1'b0;
      step();
      chk("a_nofetch", 32'(avm_read), 32'd0);
      step();
      chk("a_nofetch2", 32'(avm_read), 32'd0);

      // Misaligned load
      data_rd_req = 1'b1; data_addr = 32'h0000_1002; data_be = 4'hF;
      #1 chk("m_wait_pre", 32'(wait_request), 32'd0);
      step();
      chk("m_misal", 32'(misaligned), 32'd1);
      chk("m_read",  32'(avm_read), 32'd0);
      chk("m_wait",  32'(wait_request), 32'd0);
      data_rd_req = 1'b0;
      step();
      chk("m_misal_end", 32'(misaligned), 32'd0);
      chk("m_read_end",  32'(avm_read), 32'd0);

      // Reset during a stalled read
      data_rd_req = 1'b1; data_addr = 32'h0000_3000;
      avm_waitrequest = 1'b1;
      step();
      chk("r_read", 32'(avm_read), 32'd1);
      reset_n = 1'b0; data_rd_req = 1'b0;
      step();
      chk("r_read_rst", 32'(avm_read), 32'd0);
      chk("r_done_rst", 32'(done), 32'd0);
      chk("r_idle",     32'(wait_request), 32'd0);
      chk("r_rdata",    rdata, 32'd0);
      reset_n = 1'b1; avm_waitrequest = 1'b0;
      step();
      chk("r_done_after", 32'(done), 32'd0);
      chk("r_read_after", 32'(avm_read), 32'd0);

`ifdef MEM_PORT_TIMEOUT_EN
      // Watchdog: waitrequest stuck high, abort at the eighth wait cycle
      begin
         int edges;
         bit seen;
         edges = 0; seen = 1'b0;
         fetch_req = 1'b1; pc = 32'h0000_0040;
         avm_waitrequest = 1'b1;
         for (int i = 0; i < 20 && !seen; i++) begin
            step();
            edges++;
            if (done) seen = 1'b1;
         end
         chk("t_seen",    32'(seen), 32'd1);
         chk("t_edges",   32'(edges), 32'd9);
         chk("t_timeout", 32'(timeout), 32'd1);
         chk("t_rdata",   rdata, 32'hDEAD_BEEF);
         chk("t_read",    32'(avm_read), 32'd0);
         fetch_req = 1'b0; avm_waitrequest = 1'b0;
         step();
         chk("t_done_once", 32'(done), 32'd0);
         chk("t_sticky",    32'(timeout), 32'd1);
      end
`else
      chk("t_tied", 32'(timeout), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
